count_controller: RTL and testbench

Synchronous sequencing controller for an 8-bit event/timer counter datapath. It accepts start/stop commands, counts prescaled clock ticks from 0 to a latched terminal value, and signals completion. It runs either one-shot or auto-reload. It replaces free-running ripple chains wherever a counter must be started, stopped and observed from single-clock logic.

---
 rtl/count_ctrl_pkg.sv | 19 +
 rtl/count_controller_core.sv | 20 ++
 rtl/count_controller.sv | 120 ++++++++++++
 tb/tb_count_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count_controller block.
package count_ctrl_pkg;

  localparam int STATE_W          = 2;
  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 1;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Prescaler register width; a PRESCALE of 1 still needs a 1-bit register.
  function automatic int presc_width(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/count_controller_core.sv
// WIDTH-bit synchronous up-counter with clear (dominant) and enable.
module counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_controller.sv
// Start/stop sequencing controller for a prescaled 8-bit counter, one-shot or auto-reload.
// Optional snapshot capture port set is enabled with `define COUNT_CAPTURE_EN.
import count_ctrl_pkg::*;

module count_controller #(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               auto_reload,
  input  logic [WIDTH-1:0]   term,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic [STATE_W-1:0] dbg_state,
  output logic               done
`ifdef COUNT_CAPTURE_EN
  ,
  input  logic               capture,
  output logic [WIDTH-1:0]   cap_val,
  output logic               cap_valid
`endif
);

  localparam int            PW     = presc_width(PRESCALE);
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  state_t           state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] term_q;
  logic             mode_q;
  logic             tick;
  logic             at_term;
  logic             cnt_clr;
  logic             cnt_en;

  assign dbg_state = state;
  assign tick      = (presc == PS_MAX);
  assign at_term   = (count == term_q);

  // Stop clears in every state; a (re)start clears from IDLE/DONE; a reload clears in RUN.
  assign cnt_clr = stop
                 || ((state != RUN) && start)
                 || ((state == RUN) && tick && at_term && mode_q);
  assign cnt_en  = (state == RUN) && tick && !at_term && !stop;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      presc  <= '0;
      term_q <= '0;
      mode_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (start) begin
            term_q <= term;
            mode_q <= auto_reload;
            presc  <= '0;
            state  <= RUN;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            presc <= '0;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && at_term) begin
              done <= 1'b1;
              if (!mode_q) begin
                state <= DONE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNT_CAPTURE_EN
  // Snapshot reflects the count visible before the capturing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_val   <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= 1'b0;
      if ((state == RUN) && capture) begin
        cap_val   <= count;
        cap_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_count_controller.sv
// Self-checking bench for count_controller: PRESCALE=1 and PRESCALE=4 instances share inputs.
// Capture checks are compiled when COUNT_CAPTURE_EN is defined.
module tb_count_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;
  logic [7:0] term = 8'd0;
  logic       capture = 1'b0;

  logic [7:0] count1, count4;
  logic       busy1, busy4, done1, done4;
  logic [1:0] st1, st4;
`ifdef COUNT_CAPTURE_EN
  logic [7:0] capv1, capv4;
  logic       capvl1, capvl4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_controller #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .auto_reload(auto_reload), .term(term), .count(count1),
    .busy(busy1), .dbg_state(st1), .done(done1)
`ifdef COUNT_CAPTURE_EN
    , .capture(capture), .cap_val(capv1), .cap_valid(capvl1)
`endif
  );

  count_controller #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .auto_reload(auto_reload), .term(term), .count(count4),
    .busy(busy4), .dbg_state(st4), .done(done4)
`ifdef COUNT_CAPTURE_EN
    , .capture(capture), .cap_val(capv4), .cap_valid(capvl4)
`endif
  );

  // Reference model: elapsed cycles since start decide the count.
  typedef struct {
    bit run;
    int t;
    int term;
    bit mode;
    int count;
    bit busy;
    bit done;
    int capv;
    bit capvalid;
  } mdl_t;

  mdl_t m1, m4;

  function automatic mdl_t step(mdl_t m, int p, bit rst, bit st, bit sp,
                                bit ar, int tm, bit cp);
    mdl_t n = m;
    n.done     = 1'b0;
    n.capvalid = 1'b0;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    if (m.run && cp) begin
      n.capv     = m.count;
      n.capvalid = 1'b1;
    end
    if (m.run) begin
      if (sp) begin
        n.run   = 1'b0;
        n.count = 0;
      end else begin
        n.t = m.t + 1;
        if (n.t == (m.term + 1) * p) begin
          n.done = 1'b1;
          if (m.mode) begin
            n.t     = 0;
            n.count = 0;
          end else begin
            n.run   = 1'b0;
            n.count = m.term;
          end
        end else begin
          n.count = n.t / p;
        end
      end
    end else if (sp) begin
      n.count = 0;
    end else if (st) begin
      n.run   = 1'b1;
      n.t     = 0;
      n.term  = tm;
      n.mode  = ar;
      n.count = 0;
    end
    n.busy = n.run;
    return n;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: models consume the inputs sampled at the edge, outputs compared 1ns later.
  task automatic cyc();
    @(posedge clk);
    m1 = step(m1, 1, reset, start, stop, auto_reload, int'(term), capture);
    m4 = step(m4, 4, reset, start, stop, auto_reload, int'(term), capture);
    #1;
    check("p1_count", int'(count1), m1.count);
    check("p1_busy",  int'(busy1),  int'(m1.busy));
    check("p1_done",  int'(done1),  int'(m1.done));
    check("p4_count", int'(count4), m4.count);
    check("p4_busy",  int'(busy4),  int'(m4.busy));
    check("p4_done",  int'(done4),  int'(m4.done));
`ifdef COUNT_CAPTURE_EN
    check("p1_cap_valid", int'(capvl1), int'(m1.capvalid));
    check("p1_cap_val",   int'(capv1),  m1.capv);
    check("p4_cap_valid", int'(capvl4), int'(m4.capvalid));
    check("p4_cap_val",   int'(capv4),  m4.capv);
`endif
  endtask

  typedef struct {
    logic       st;
    logic       sp;
    logic       ar;
    logic [7:0] tm;
    int         ec;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int  t_done[3];
    int  nd;
    bit  seen;

    m1 = '{default: 0};
    m4 = '{default: 0};

    // One-shot term=3 on the PRESCALE=1 instance, then stop/start collisions.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd3, 0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 8'd3, 1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 8'd3, 2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'd3, 3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'd3, 3, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'd3, 3, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'd3, 0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'd0, 0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 8'd0, 0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0, 1'b0};

    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 10; i++) begin
      start       = tbl[i].st;
      stop        = tbl[i].sp;
      auto_reload = tbl[i].ar;
      term        = tbl[i].tm;
      cyc();
      check($sformatf("tbl%0d_count", i), int'(count1), tbl[i].ec);
      check($sformatf("tbl%0d_busy", i),  int'(busy1),  int'(tbl[i].eb));
      check($sformatf("tbl%0d_done", i),  int'(done1),  int'(tbl[i].ed));
    end
    start = 1'b0;
    stop  = 1'b0;

    // Reset held 3 cycles in the middle of an auto-reload run.
    term        = 8'd200;
    auto_reload = 1'b1;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_count", int'(count1), 0);
      check("rst_busy",  int'(busy1),  0);
      check("rst_done",  int'(done1),  0);
    end
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done1 || done4) seen = 1'b1;
    end
    check("rst_no_spurious_done", int'(seen), 0);

    // Auto-reload term=2: PRESCALE=4 instance pulses done every 12 cycles.
    term        = 8'd2;
    auto_reload = 1'b1;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    nd    = 0;
    for (int c = 1; c <= 60 && nd < 3; c++) begin
      cyc();
      if (done4) begin
        t_done[nd] = c;
        nd++;
      end
    end
    check("ar_done_pulses", nd, 3);
    if (nd == 3) begin
      check("ar_first_done", t_done[0], 12);
      check("ar_period_a", t_done[1] - t_done[0], 12);
      check("ar_period_b", t_done[2] - t_done[1], 12);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("ar_stop_count", int'(count4), 0);

    // term changed mid-run has no effect; restart from DONE relatches.
    term        = 8'd5;
    auto_reload = 1'b0;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    term = 8'd1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (done1) seen = 1'b1;
    end
    check("tc_first_done_seen", int'(seen), 1);
    check("tc_first_end", int'(count1), 5);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("tc_restart_busy", int'(busy1), 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (done1) seen = 1'b1;
    end
    check("tc_second_done_seen", int'(seen), 1);
    check("tc_second_end", int'(count1), 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

`ifdef COUNT_CAPTURE_EN
    // Capture when count reads 6; capture in IDLE is ignored.
    term        = 8'd10;
    auto_reload = 1'b0;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (count1 == 8'd6) seen = 1'b1;
      else cyc();
    end
    check("cap_reach6", int'(seen), 1);
    capture = 1'b1;
    cyc();
    capture = 1'b0;
    check("cap_val6", int'(capv1), 6);
    check("cap_valid_hi", int'(capvl1), 1);
    cyc();
    check("cap_valid_lo", int'(capvl1), 0);
    stop = 1'b1;
    cyc();
    stop    = 1'b0;
    capture = 1'b1;
    cyc();
    capture = 1'b0;
    check("cap_idle_ignored", int'(capvl1), 0);
    check("cap_idle_hold", int'(capv1), 6);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      start       = ($urandom_range(0, 3) == 0);
      stop        = ($urandom_range(0, 24) == 0);
      auto_reload = 1'($urandom_range(0, 1));
      term        = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 6));
      capture     = ($urandom_range(0, 4) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
